// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline_delay line.
package pipeline_pkg;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipeline_delay_stage.sv
// One register stage of the delay line: {valid, data} with enable and flush.
module pipeline_delay_stage
   import pipeline_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_d
);

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } stage_t;

   stage_t stage_d;
   stage_t stage_q;

   always_comb begin
      stage_d = stage_q;
      if (i_clr) begin
         stage_d = '{valid: 1'b0, data: RESET_VALUE};
      end else if (i_en) begin
         stage_d = '{valid: i_valid, data: i_d};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stage_q <= '{valid: 1'b0, data: RESET_VALUE};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign o_valid = stage_q.valid;
   assign o_d     = stage_q.data;

endmodule

// File: rtl/pipeline_delay.sv
// Parametrised delay line with per-beat valid, stall, flush and occupancy.
module pipeline_delay
   import pipeline_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_en,
   input  logic                          i_clr,
   input  logic                          i_valid,
   input  logic [WIDTH-1:0]              i_d,
   output logic                          o_valid,
   output logic [WIDTH-1:0]              o_d,
   output logic [occ_width(DEPTH)-1:0]   o_occupancy
);

   localparam int OW = occ_width(DEPTH);

   logic [DEPTH:0]   v_chain;
   logic [WIDTH-1:0] d_chain [DEPTH+1];

   assign v_chain[0] = i_valid;
   assign d_chain[0] = i_d;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipeline_delay_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_en    (i_en),
         .i_clr   (i_clr),
         .i_valid (v_chain[k]),
         .i_d     (d_chain[k]),
         .o_valid (v_chain[k+1]),
         .o_d     (d_chain[k+1])
      );
   end

   logic [OW-1:0] occ_d;
   logic [OW-1:0] occ_q;

   // Entry and exit on the same shift cancel, so occ tracks popcount(v).
   always_comb begin
      occ_d = occ_q;
      if (i_clr) begin
         occ_d = '0;
      end else if (i_en) begin
         occ_d = occ_q + OW'(i_valid) - OW'(v_chain[DEPTH]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign o_valid     = v_chain[DEPTH];
   assign o_d         = d_chain[DEPTH];
   assign o_occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_delay.sv
// Self-checking bench for pipeline_delay at three parameter points.
module tb_pipeline_delay;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       en4, clr4, v4, ov4;
   logic [7:0] d4, od4;
   logic [2:0] occ4;

   logic       en1, clr1, v1, ov1;
   logic [0:0] d1, od1;
   logic [0:0] occ1;

   logic        en7, clr7, v7, ov7;
   logic [31:0] d7, od7;
   logic [2:0]  occ7;

   localparam logic [7:0]  RV4 = 8'h3C;
   localparam logic [31:0] RV7 = 32'hDEAD_BEEF;

   pipeline_delay #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(RV4)) u_d4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .i_clr(clr4),
      .i_valid(v4), .i_d(d4), .o_valid(ov4), .o_d(od4),
      .o_occupancy(occ4)
   );

   pipeline_delay #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) u_d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_clr(clr1),
      .i_valid(v1), .i_d(d1), .o_valid(ov1), .o_d(od1),
      .o_occupancy(occ1)
   );

   pipeline_delay #(.WIDTH(32), .DEPTH(7), .RESET_VALUE(RV7)) u_d7 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en7), .i_clr(clr7),
      .i_valid(v7), .i_d(d7), .o_valid(ov7), .o_d(od7),
      .o_occupancy(occ7)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step4(input logic en, input logic clr,
                        input logic v, input logic [7:0] d);
      en4  = en;
      clr4 = clr;
      v4   = v;
      d4   = d;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       en;
      logic       clr;
      logic       v;
      logic [7:0] d;
      logic       exp_v;
      logic [7:0] exp_d;
      logic [2:0] exp_occ;
   } vec_t;

   typedef struct {
      logic        v;
      logic [31:0] d;
   } beat_t;

   vec_t       vecs [7];
   logic [7:0] got [$];
   beat_t      m7 [$];
   beat_t      m1 [$];
   int         first_edge;
   int         cnt;

   initial begin
      rst_n = 1'b0;
      en4 = 0; clr4 = 0; v4 = 0; d4 = '0;
      en1 = 0; clr1 = 0; v1 = 0; d1 = '0;
      en7 = 0; clr7 = 0; v7 = 0; d7 = '0;

      // Single beat 0xA5 through DEPTH=4, then a hold and a flush.
      vecs[0] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, RV4,   3'd1};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, RV4,   3'd1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, RV4,   3'd1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 8'hA5, 3'd1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 8'h11, 3'd0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 8'h11, 3'd0};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, RV4,   3'd0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_d4_valid", ov4, 0);
      chk("rst_d4_data", od4, RV4);
      chk("rst_d4_occ", occ4, 0);
      chk("rst_d1_valid", ov1, 0);
      chk("rst_d1_occ", occ1, 0);
      chk("rst_d7_valid", ov7, 0);
      chk("rst_d7_data", od7, RV7);
      chk("rst_d7_occ", occ7, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         step4(vecs[i].en, vecs[i].clr, vecs[i].v, vecs[i].d);
         chk($sformatf("vec%0d_valid", i), ov4, vecs[i].exp_v);
         chk($sformatf("vec%0d_data", i), od4, vecs[i].exp_d);
         chk($sformatf("vec%0d_occ", i), occ4, vecs[i].exp_occ);
      end

      // Stall for 3 cycles in the middle of a 6-beat stream.
      got.delete();
      first_edge = 0;
      for (int e = 1; e <= 16; e++) begin
         if (e <= 3) step4(1'b1, 1'b0, 1'b1, 8'(e));
         else if (e <= 6) step4(1'b0, 1'b0, 1'b1, 8'hEE);
         else if (e <= 9) step4(1'b1, 1'b0, 1'b1, 8'(e - 3));
         else step4(1'b1, 1'b0, 1'b0, 8'h00);
         if (e >= 4 && e <= 6) chk("stall_occ_hold", occ4, 3);
         if (ov4) begin
            if (first_edge == 0) first_edge = e;
            got.push_back(od4);
         end
      end
      chk("stall_first_edge", first_edge, 7);
      chk("stall_beat_count", got.size(), 6);
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("stall_order%0d", i), got[i], i + 1);

      // Continuous valid input saturates occupancy at DEPTH.
      for (int k = 1; k <= 8; k++) begin
         step4(1'b1, 1'b0, 1'b1, 8'(8'h40 + k));
         chk($sformatf("full_occ%0d", k), occ4, (k < 4) ? k : 4);
         if (k >= 4) begin
            chk("full_valid", ov4, 1);
            chk("full_data", od4, 8'(8'h40 + k - 3));
         end
      end

      // Flush with 4 beats in flight; the 0xFF beat must be discarded.
      step4(1'b1, 1'b1, 1'b1, 8'hFF);
      chk("flush_valid", ov4, 0);
      chk("flush_occ", occ4, 0);
      chk("flush_data", od4, RV4);
      for (int k = 0; k < 5; k++) begin
         step4(1'b1, 1'b0, 1'b0, 8'h00);
         chk("post_flush_valid", ov4, 0);
         chk("post_flush_no_ff", od4 == 8'hFF, 0);
      end

      // Asynchronous reset between edges with 3 beats in flight.
      for (int k = 0; k < 3; k++) step4(1'b1, 1'b0, 1'b1, 8'(8'h60 + k));
      chk("pre_rst_occ", occ4, 3);
      en4 = 1'b1; v4 = 1'b1; d4 = 8'h77;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", ov4, 0);
      chk("async_rst_data", od4, RV4);
      chk("async_rst_occ", occ4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step4(1'b0, 1'b0, 1'b0, 8'h00);
      chk("post_rst_occ", occ4, 0);
      chk("post_rst_data", od4, RV4);

      // Random stimulus on DEPTH=7 and DEPTH=1 against queue models.
      m7.delete();
      m1.delete();
      for (int i = 0; i < 7; i++) m7.push_back('{1'b0, RV7});
      m1.push_back('{1'b0, 32'h0});
      for (int c = 0; c < 800; c++) begin
         en7  = ($urandom_range(3) != 0);
         clr7 = ($urandom_range(40) == 0);
         v7   = 1'($urandom_range(1));
         d7   = $urandom;
         en1  = ($urandom_range(4) != 0);
         clr1 = ($urandom_range(40) == 0);
         v1   = 1'($urandom_range(1));
         d1   = 1'($urandom_range(1));
         @(posedge clk);
         #1;
         if (clr7) begin
            foreach (m7[i]) m7[i] = '{1'b0, RV7};
         end else if (en7) begin
            m7.push_front('{v7, d7});
            void'(m7.pop_back());
         end
         if (clr1) begin
            m1[0] = '{1'b0, 32'h0};
         end else if (en1) begin
            m1[0] = '{v1, {31'b0, d1}};
         end
         cnt = 0;
         foreach (m7[i]) cnt += int'(m7[i].v);
         chk("rnd7_valid", ov7, m7[6].v);
         chk("rnd7_data", od7, m7[6].d);
         chk("rnd7_occ", occ7, cnt);
         chk("rnd1_valid", ov1, m1[0].v);
         chk("rnd1_data", od1, m1[0].d);
         chk("rnd1_occ", occ1, int'(m1[0].v));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
